// File: rtl/fb_line_fetch_if.sv
// Word-addressed memory read port between fb_line_fetch (master) and the memory arbiter (slave).
interface fb_line_fetch_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/fb_line_fetch.sv
// Prefetches the next 1bpp framebuffer line into a ping-pong buffer and serves pixels with 1-cycle latency.
// Define FB_LINE_FETCH_STATS_EN to add underrun_count and frame_count outputs.
module fb_line_fetch #(
  parameter int unsigned FB_WIDTH  = 512,
  parameter int unsigned FB_HEIGHT = 512,
  parameter int unsigned V_TOTAL   = 628,
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned FB_BASE   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [9:0]      x,
  input  logic [9:0]      y,
  fb_line_fetch_if.master mem,
  output logic            framebuffer_pixel,
  output logic            busy,
  output logic            underrun
`ifdef FB_LINE_FETCH_STATS_EN
  ,
  output logic [7:0]      underrun_count,
  output logic [15:0]     frame_count
`endif
);

  localparam int unsigned WORDS = FB_WIDTH / 16;
  localparam int unsigned WI_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned XY_W  = 10;
  localparam int unsigned YI_W  = XY_W + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state, state_nx;
  logic [XY_W-1:0]   tgt, tgt_nx, t_new;
  logic [WI_W-1:0]   widx, widx_nx;
  logic [1:0]        valid, valid_nx;
  logic [YI_W-1:0]   y_inc;
  logic [ADDR_W-1:0] addr_nx;
  logic [15:0]       rd_word;
  logic              trig, overrun, wr_en, last_w, underrun_nx, pix_nx;

  logic [15:0] line_buf [2][WORDS];

  // Trigger decode: prefetch line y+1, or line 0 on the last line of the frame
  always_comb begin
    trig  = 1'b0;
    t_new = '0;
    y_inc = {1'b0, y} + YI_W'(1);
    if (x == XY_W'(FB_WIDTH)) begin
      if (y_inc < YI_W'(FB_HEIGHT)) begin
        trig  = 1'b1;
        t_new = y_inc[XY_W-1:0];
      end else if (y == XY_W'(V_TOTAL - 1)) begin
        trig  = 1'b1;
      end
    end
  end

  // Fetch FSM next-state; a trigger always wins over an ack in the same cycle
  always_comb begin
    state_nx    = state;
    tgt_nx      = tgt;
    widx_nx     = widx;
    valid_nx    = valid;
    underrun_nx = underrun;
    overrun     = 1'b0;
    wr_en       = 1'b0;
    last_w      = (widx == WI_W'(WORDS - 1));
    if (trig) begin
      overrun            = (state == REQ);
      underrun_nx        = underrun | overrun;
      valid_nx[t_new[0]] = 1'b0;
      tgt_nx             = t_new;
      widx_nx            = '0;
      state_nx           = REQ;
    end else if ((state == REQ) && mem.mem_ack) begin
      wr_en = 1'b1;
      if (last_w) begin
        valid_nx[tgt[0]] = 1'b1;
        state_nx         = IDLE;
      end else begin
        widx_nx = widx + WI_W'(1);
      end
    end
    addr_nx = ADDR_W'(FB_BASE) + ADDR_W'(tgt_nx) * ADDR_W'(WORDS) + ADDR_W'(widx_nx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tgt          <= '0;
      widx         <= '0;
      valid        <= '0;
      underrun     <= 1'b0;
      busy         <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
    end else begin
      state       <= state_nx;
      tgt         <= tgt_nx;
      widx        <= widx_nx;
      valid       <= valid_nx;
      underrun    <= underrun_nx;
      busy        <= (state_nx == REQ);
      mem.mem_req <= (state_nx == REQ);
      if (state_nx == REQ) mem.mem_addr <= addr_nx;
    end
  end

  // Line buffer storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) line_buf[tgt[0]][widx] <= mem.mem_rdata;
  end

  // Pixel path: bit 15 of each word is the leftmost pixel
  always_comb begin
    rd_word = line_buf[y[0]][x[WI_W+3:4]];
    pix_nx  = (x < XY_W'(FB_WIDTH)) && (y < XY_W'(FB_HEIGHT)) && valid[y[0]] && rd_word[~x[3:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) framebuffer_pixel <= 1'b0;
    else     framebuffer_pixel <= pix_nx;
  end

`ifdef FB_LINE_FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_count <= '0;
      frame_count    <= '0;
    end else begin
      if (overrun && (underrun_count != 8'd255)) underrun_count <= underrun_count + 8'd1;
      if (wr_en && last_w && (tgt == '0)) frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_line_fetch.sv
// Scoreboard bench for fb_line_fetch: expected addresses and pixels are queued by stimulus, checked by monitors.
module tb_fb_line_fetch;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned WORDS  = 32;

  typedef struct packed {
    logic [9:0] px;
    logic [9:0] py;
    logic       p;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic       framebuffer_pixel, busy, underrun;
`ifdef FB_LINE_FETCH_STATS_EN
  logic [7:0]  underrun_count;
  logic [15:0] frame_count;
`endif

  fb_line_fetch_if #(.ADDR_W(ADDR_W)) mem ();

  fb_line_fetch #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .mem(mem),
    .framebuffer_pixel(framebuffer_pixel), .busy(busy), .underrun(underrun)
`ifdef FB_LINE_FETCH_STATS_EN
    , .underrun_count(underrun_count), .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass = 0;
  pix_t pix_q[$];
  int unsigned addr_q[$];
  bit   pix_chk = 1'b0;
  bit   pix_chk_d = 1'b0;
  bit   hold_ack = 1'b0;
  bit   force_ack = 1'b0;
  int   lat = 0;
  int   acks_seen = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic bit model_pix(input int line, input int xv, input int yv, input bit vld);
    logic [15:0] w;
    if (xv >= 512 || yv >= 512 || !vld) return 1'b0;
    w = {8'(line), 8'(xv / 16)};
    return w[15 - (xv % 16)];
  endfunction

  function automatic logic [15:0] model_word(input int unsigned addr);
    return {8'(addr / WORDS), 8'(addr % WORDS)};
  endfunction

  // Pixel monitor: output for the beam driven one cycle earlier
  always @(posedge clk) pix_chk_d <= pix_chk;
  always @(negedge clk) begin
    if (pix_chk_d) begin
      if (pix_q.size() == 0) check("pixel_queue_empty", 1, 0);
      else begin
        pix_t e;
        e = pix_q.pop_front();
        check($sformatf("pixel x=%0d y=%0d", e.px, e.py), framebuffer_pixel, e.p);
      end
    end
  end

  // Memory responder: acks after 'lat' idle cycles and checks each acked address
  initial begin
    int cnt;
    cnt = 0;
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (rst || hold_ack || !mem.mem_req) begin
        mem.mem_ack = force_ack;
        if (force_ack) mem.mem_rdata = 16'hFFFF;
        cnt = 0;
      end else if (cnt >= lat) begin
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = model_word(32'(mem.mem_addr));
        cnt = 0;
        acks_seen++;
        if (addr_q.size() == 0) check("unexpected_req", 1, 0);
        else check("mem_addr", mem.mem_addr, addr_q.pop_front());
      end else begin
        mem.mem_ack = 1'b0;
        cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int xv, input int yv, input bit chk, input bit ev);
    pix_t e;
    x = 10'(xv);
    y = 10'(yv);
    pix_chk = chk;
    if (chk) begin
      e.px = 10'(xv); e.py = 10'(yv); e.p = ev;
      pix_q.push_back(e);
    end
    tick();
  endtask

  task automatic sweep(input int yv, input int x0, input int x1, input int line, input bit vld);
    for (int xi = x0; xi <= x1; xi++) drive(xi, yv, 1'b1, model_pix(line, xi, yv, vld));
    pix_chk = 1'b0;
  endtask

  task automatic trigger(input int yv, input int t, input bit fetch, input bit ovr);
    if (ovr) begin
      addr_q.delete();
      hold_ack = 1'b1;
    end
    if (fetch) for (int i = 0; i < int'(WORDS); i++) addr_q.push_back(32'(t * int'(WORDS) + i));
    drive(512, yv, 1'b0, 1'b0);
    hold_ack = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int yv, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      drive(600, yv, 1'b0, 1'b0);
      n++;
    end
    check(name, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mem_req", mem.mem_req, 0);
    check("rst_mem_addr", mem.mem_addr, 0);
    check("rst_pixel", framebuffer_pixel, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);

    // Zero-wait fetch of line 11
    sweep(11, 0, 15, 11, 1'b0);
    trigger(10, 11, 1'b1, 1'b0);
    drive(513, 10, 1'b0, 1'b0);
    check("busy_during_fetch", busy, 1);
    for (int xi = 514; xi <= 600; xi++) drive(xi, 10, 1'b0, 1'b0);
    check("busy_low_by_x600", busy, 0);
    check("fetch11_all_acked", addr_q.size(), 0);
    sweep(10, 0, 31, 10, 1'b0);
    sweep(11, 0, 511, 11, 1'b1);
    sweep(11, 513, 799, 11, 1'b1);
    sweep(521, 0, 63, 11, 1'b1);

    // Line 511 has no successor inside the frame
    trigger(511, 0, 1'b0, 1'b0);
    repeat (5) drive(513, 511, 1'b0, 1'b0);
    check("no_fetch_busy", busy, 0);
    check("no_fetch_req", mem.mem_req, 0);

    // Frame wrap fetches line 0 at FB_BASE
    trigger(627, 0, 1'b1, 1'b0);
    wait_idle("wrap_done", 627, 200);
    sweep(0, 0, 511, 0, 1'b1);
    sweep(600, 0, 31, 0, 1'b1);
`ifdef FB_LINE_FETCH_STATS_EN
    check("frame_count_1", frame_count, 1);
`endif

    // Slow memory: second trigger lands mid-fetch
    lat = 40;
    trigger(20, 21, 1'b1, 1'b0);
    for (int xi = 513; xi <= 799; xi++) drive(xi, 20, 1'b0, 1'b0);
    sweep(21, 0, 511, 21, 1'b0);
    trigger(21, 22, 1'b1, 1'b1);
    check("underrun_set", underrun, 1);
    drive(513, 21, 1'b0, 1'b0);
    check("busy_after_restart", busy, 1);
    wait_idle("slow_done", 21, 3000);
    check("fetch22_all_acked", addr_q.size(), 0);
    sweep(21, 0, 511, 21, 1'b0);
    sweep(22, 0, 511, 22, 1'b1);
`ifdef FB_LINE_FETCH_STATS_EN
    check("underrun_count_1", underrun_count, 1);
`endif

    // Repeated overruns
    for (int i = 0; i < 300; i++) begin
      trigger(20, 21, 1'b1, 1'b1);
      drive(513, 20, 1'b0, 1'b0);
    end
    check("underrun_sticky", underrun, 1);
`ifdef FB_LINE_FETCH_STATS_EN
    check("underrun_count_sat", underrun_count, 255);
`endif
    lat = 0;
    wait_idle("line21_done", 20, 200);

    // Reset asserted while fetching word 7
    a0 = acks_seen;
    trigger(30, 31, 1'b1, 1'b0);
    n = 0;
    while ((acks_seen - a0) < 7 && n < 100) begin
      drive(21, 22, 1'b0, 1'b0);
      n++;
    end
    check("reached_word7", acks_seen - a0, 7);
    check("pixel_before_reset", framebuffer_pixel, 1);
    hold_ack = 1'b1;
    rst = 1'b1;
    #1;
    check("midrst_mem_req", mem.mem_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pixel", framebuffer_pixel, 0);
    check("midrst_mem_addr", mem.mem_addr, 0);
    check("midrst_underrun", underrun, 0);
`ifdef FB_LINE_FETCH_STATS_EN
    check("midrst_underrun_count", underrun_count, 0);
    check("midrst_frame_count", frame_count, 0);
`endif
    addr_q.delete();
    tick();
    tick();
    rst = 1'b0;
    hold_ack = 1'b0;
    force_ack = 1'b1;
    drive(600, 30, 1'b0, 1'b0);
    force_ack = 1'b0;
    drive(600, 30, 1'b0, 1'b0);
    check("late_ack_busy", busy, 0);
    check("late_ack_req", mem.mem_req, 0);
    sweep(31, 0, 63, 31, 1'b0);
    sweep(22, 0, 63, 22, 1'b0);
    tick();
    tick();
    check("pixel_queue_drained", pix_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
